// File: rtl/game_ctrl_pkg.sv
// Shared types and default tuning constants for the target/torpedo round controller.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    PLAY,
    RETARGET,
    LOST,
    OVER
  } game_state_t;

  localparam int DEFAULT_LIVES      = 3;
  localparam int DEFAULT_SPEED_MAX  = 7;
  localparam int DEFAULT_SPEED_STEP = 5;

endpackage

// File: rtl/game_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after din rises.
module game_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic prev;

  // Remember the last sample and register the rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= din;
      pulse <= din & ~prev;
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// Master sequencer for the target/torpedo game: round flow, lives, score, difficulty.
module game_round_controller
  import game_ctrl_pkg::*;
#(
  parameter int LIVES      = DEFAULT_LIVES,
  parameter int LIVES_W    = 2,
  parameter int SCORE_W    = 16,
  parameter int SPEED_W    = 4,
  parameter int SPEED_MAX  = DEFAULT_SPEED_MAX,
  parameter int SPEED_STEP = DEFAULT_SPEED_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch_key,
  input  logic               target_within_screen,
  input  logic               torpedo_within_screen,
  input  logic               collision,
  input  logic               target_hit_wall,
  input  logic               timer_running,
  output logic               target_write_xy,
  output logic               target_write_dxy,
  output logic               torpedo_write_xy,
  output logic               torpedo_write_dxy,
  output logic               target_enable_update,
  output logic               torpedo_enable_update,
  output logic               timer_start,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam int HIT_W = $clog2(SPEED_STEP + 1);

  game_state_t        state, state_n;
  logic [HIT_W-1:0]   hit_cnt, hit_n;
  logic [SPEED_W-1:0] speed_n;
  logic [SCORE_W-1:0] score_n;
  logic [LIVES_W-1:0] lives_n;
  logic               guard, guard_n;
  logic               torpedo_holdoff, holdoff_n;
  logic               torpedo_evt;
  logic               target_write_xy_n, target_write_dxy_n;
  logic               torpedo_write_xy_n, torpedo_write_dxy_n;
  logic               target_enable_n, torpedo_enable_n;
  logic               timer_start_n, game_over_n;
  logic               key_edge, wall_edge;

  game_edge_detect u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (launch_key),
    .pulse (key_edge)
  );

  game_edge_detect u_wall_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (target_hit_wall),
    .pulse (wall_edge)
  );

  // State register plus every registered output and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      hit_cnt               <= '0;
      speed                 <= SPEED_W'(1);
      score                 <= '0;
      lives                 <= LIVES_W'(LIVES);
      guard                 <= 1'b0;
      torpedo_holdoff       <= 1'b0;
      target_write_xy       <= 1'b0;
      target_write_dxy      <= 1'b0;
      torpedo_write_xy      <= 1'b0;
      torpedo_write_dxy     <= 1'b0;
      target_enable_update  <= 1'b0;
      torpedo_enable_update <= 1'b0;
      timer_start           <= 1'b0;
      game_over             <= 1'b0;
    end else begin
      state                 <= state_n;
      hit_cnt               <= hit_n;
      speed                 <= speed_n;
      score                 <= score_n;
      lives                 <= lives_n;
      guard                 <= guard_n;
      torpedo_holdoff       <= holdoff_n;
      target_write_xy       <= target_write_xy_n;
      target_write_dxy      <= target_write_dxy_n;
      torpedo_write_xy      <= torpedo_write_xy_n;
      torpedo_write_dxy     <= torpedo_write_dxy_n;
      target_enable_update  <= target_enable_n;
      torpedo_enable_update <= torpedo_enable_n;
      timer_start           <= timer_start_n;
      game_over             <= game_over_n;
    end
  end

  // Next state, counter updates and next-cycle output values
  always_comb begin
    state_n       = state;
    hit_n         = hit_cnt;
    speed_n       = speed;
    score_n       = score;
    lives_n       = lives;
    holdoff_n     = 1'b0;
    torpedo_evt   = 1'b0;
    timer_start_n = 1'b0;

    case (state)
      IDLE: begin
        if (key_edge) state_n = SPAWN;
      end
      SPAWN: begin
        state_n = PLAY;
      end
      PLAY: begin
        if (collision) begin
          lives_n       = lives - 1'b1;
          timer_start_n = 1'b1;
          speed_n       = SPEED_W'(1);
          state_n       = (lives == LIVES_W'(1)) ? OVER : LOST;
        end else if (!target_within_screen) begin
          state_n = RETARGET;
        end else if (!torpedo_within_screen && !torpedo_holdoff) begin
          torpedo_evt = 1'b1;
          holdoff_n   = 1'b1;
        end else if (wall_edge) begin
          if (score != '1) score_n = score + 1'b1;
          hit_n = hit_cnt + 1'b1;
          if (hit_n == HIT_W'(SPEED_STEP)) begin
            hit_n = '0;
            if (speed < SPEED_W'(SPEED_MAX)) speed_n = speed + 1'b1;
          end
        end
      end
      RETARGET: begin
        state_n = PLAY;
      end
      LOST: begin
        if (guard && !timer_running) state_n = SPAWN;
      end
      OVER: begin
        if (guard && !timer_running && key_edge) begin
          score_n = '0;
          hit_n   = '0;
          lives_n = LIVES_W'(LIVES);
          speed_n = SPEED_W'(1);
          state_n = SPAWN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    guard_n             = (state_n == state);
    target_write_xy_n   = (state_n == SPAWN) || (state_n == RETARGET);
    target_write_dxy_n  = (state_n == SPAWN) || (state_n == RETARGET);
    torpedo_write_xy_n  = (state_n == SPAWN) || torpedo_evt;
    torpedo_write_dxy_n = (state_n == SPAWN) || (state_n == PLAY);
    target_enable_n     = (state_n == PLAY) || (state_n == RETARGET);
    torpedo_enable_n    = (state_n == PLAY) || (state_n == RETARGET);
    game_over_n         = (state_n == OVER);
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed self-checking bench for game_round_controller.
module tb_game_round_controller;

  logic        clk;
  logic        rst;
  logic        launch_key;
  logic        target_within_screen;
  logic        torpedo_within_screen;
  logic        collision;
  logic        target_hit_wall;
  logic        timer_running;
  logic        target_write_xy;
  logic        target_write_dxy;
  logic        torpedo_write_xy;
  logic        torpedo_write_dxy;
  logic        target_enable_update;
  logic        torpedo_enable_update;
  logic        timer_start;
  logic [3:0]  speed;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  game_round_controller dut (
    .clk                   (clk),
    .rst                   (rst),
    .launch_key            (launch_key),
    .target_within_screen  (target_within_screen),
    .torpedo_within_screen (torpedo_within_screen),
    .collision             (collision),
    .target_hit_wall       (target_hit_wall),
    .timer_running         (timer_running),
    .target_write_xy       (target_write_xy),
    .target_write_dxy      (target_write_dxy),
    .torpedo_write_xy      (torpedo_write_xy),
    .torpedo_write_dxy     (torpedo_write_dxy),
    .target_enable_update  (target_enable_update),
    .torpedo_enable_update (torpedo_enable_update),
    .timer_start           (timer_start),
    .speed                 (speed),
    .score                 (score),
    .lives                 (lives),
    .game_over             (game_over)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles; sampling point is 1 unit after each rising edge
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("[TB] check %s differs", tag);
    end
  endtask

  // One wall bounce: level high one cycle, low one cycle; score settles after
  task automatic wallPulse();
    target_hit_wall = 1'b1;
    applyStimulus(1);
    target_hit_wall = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    rst                   = 1'b1;
    launch_key            = 1'b0;
    target_within_screen  = 1'b1;
    torpedo_within_screen = 1'b1;
    collision             = 1'b0;
    target_hit_wall       = 1'b0;
    timer_running         = 1'b0;

    // Reset state
    applyStimulus(2);
    checkOutput("rst_lives", 32'(lives), 3);
    checkOutput("rst_speed", 32'(speed), 1);
    checkOutput("rst_score", 32'(score), 0);
    checkOutput("rst_game_over", 32'(game_over), 0);
    checkOutput("rst_tgt_xy", 32'(target_write_xy), 0);
    checkOutput("rst_tgt_en", 32'(target_enable_update), 0);
    checkOutput("rst_timer_start", 32'(timer_start), 0);
    rst = 1'b0;
    applyStimulus(2);
    checkOutput("idle_trp_en", 32'(torpedo_enable_update), 0);

    // Launch: edge detected, then SPAWN strobes, then PLAY
    launch_key = 1'b1;
    applyStimulus(1);
    checkOutput("pre_spawn_tgt_xy", 32'(target_write_xy), 0);
    applyStimulus(1);
    checkOutput("spawn_tgt_xy", 32'(target_write_xy), 1);
    checkOutput("spawn_tgt_dxy", 32'(target_write_dxy), 1);
    checkOutput("spawn_trp_xy", 32'(torpedo_write_xy), 1);
    checkOutput("spawn_trp_dxy", 32'(torpedo_write_dxy), 1);
    checkOutput("spawn_tgt_en", 32'(target_enable_update), 0);
    launch_key = 1'b0;
    applyStimulus(1);
    checkOutput("play_tgt_en", 32'(target_enable_update), 1);
    checkOutput("play_trp_en", 32'(torpedo_enable_update), 1);
    checkOutput("play_tgt_xy", 32'(target_write_xy), 0);
    checkOutput("play_trp_xy", 32'(torpedo_write_xy), 0);
    checkOutput("play_trp_dxy", 32'(torpedo_write_dxy), 1);
    checkOutput("play_score", 32'(score), 0);
    checkOutput("play_lives", 32'(lives), 3);
    checkOutput("play_speed", 32'(speed), 1);

    // Wall hits: 12 -> speed 3, 40 -> speed saturated at 7
    for (int i = 0; i < 12; i++) wallPulse();
    checkOutput("hits12_score", 32'(score), 12);
    checkOutput("hits12_speed", 32'(speed), 3);
    for (int i = 0; i < 28; i++) wallPulse();
    checkOutput("hits40_score", 32'(score), 40);
    checkOutput("hits40_speed", 32'(speed), 7);

    // Launch key in PLAY has no effect
    launch_key = 1'b1;
    applyStimulus(2);
    launch_key = 1'b0;
    checkOutput("play_key_tgt_xy", 32'(target_write_xy), 0);
    checkOutput("play_key_en", 32'(target_enable_update), 1);

    // First collision -> LOST
    collision = 1'b1;
    applyStimulus(1);
    checkOutput("col1_lives", 32'(lives), 2);
    checkOutput("col1_timer_start", 32'(timer_start), 1);
    checkOutput("col1_tgt_en", 32'(target_enable_update), 0);
    checkOutput("col1_trp_en", 32'(torpedo_enable_update), 0);
    checkOutput("col1_speed", 32'(speed), 1);
    checkOutput("col1_game_over", 32'(game_over), 0);
    collision     = 1'b0;
    timer_running = 1'b1;
    target_hit_wall = 1'b1;
    applyStimulus(1);
    checkOutput("col1_timer_pulse_end", 32'(timer_start), 0);
    target_hit_wall = 1'b0;
    applyStimulus(99);
    checkOutput("lost_wait_en", 32'(target_enable_update), 0);
    checkOutput("lost_wait_tgt_xy", 32'(target_write_xy), 0);
    timer_running = 1'b0;
    applyStimulus(1);
    checkOutput("respawn_tgt_dxy", 32'(target_write_dxy), 1);
    checkOutput("respawn_trp_xy", 32'(torpedo_write_xy), 1);
    applyStimulus(1);
    checkOutput("respawn_play_en", 32'(torpedo_enable_update), 1);
    checkOutput("respawn_score", 32'(score), 40);
    checkOutput("respawn_speed", 32'(speed), 1);

    // Second collision -> LOST, short timer
    collision = 1'b1;
    applyStimulus(1);
    checkOutput("col2_lives", 32'(lives), 1);
    collision     = 1'b0;
    timer_running = 1'b1;
    applyStimulus(3);
    timer_running = 1'b0;
    applyStimulus(2);
    checkOutput("col2_play_en", 32'(target_enable_update), 1);

    // Third collision -> OVER
    collision = 1'b1;
    applyStimulus(1);
    checkOutput("col3_lives", 32'(lives), 0);
    checkOutput("col3_game_over", 32'(game_over), 1);
    checkOutput("col3_timer_start", 32'(timer_start), 1);
    checkOutput("col3_en", 32'(target_enable_update), 0);
    collision     = 1'b0;
    timer_running = 1'b1;
    applyStimulus(2);
    launch_key = 1'b1;
    applyStimulus(2);
    checkOutput("over_busy_key_go", 32'(game_over), 1);
    checkOutput("over_busy_key_lives", 32'(lives), 0);
    checkOutput("over_busy_key_tgt_xy", 32'(target_write_xy), 0);
    launch_key = 1'b0;
    applyStimulus(2);
    timer_running = 1'b0;
    applyStimulus(2);
    checkOutput("over_idle_go", 32'(game_over), 1);
    launch_key = 1'b1;
    applyStimulus(2);
    checkOutput("restart_score", 32'(score), 0);
    checkOutput("restart_lives", 32'(lives), 3);
    checkOutput("restart_go", 32'(game_over), 0);
    checkOutput("restart_tgt_xy", 32'(target_write_xy), 1);
    checkOutput("restart_speed", 32'(speed), 1);
    launch_key = 1'b0;
    applyStimulus(1);

    // Target leaves screen -> RETARGET strobes once
    target_within_screen = 1'b0;
    applyStimulus(1);
    checkOutput("retgt_tgt_xy", 32'(target_write_xy), 1);
    checkOutput("retgt_tgt_dxy", 32'(target_write_dxy), 1);
    checkOutput("retgt_tgt_en", 32'(target_enable_update), 1);
    checkOutput("retgt_trp_xy", 32'(torpedo_write_xy), 0);
    target_within_screen = 1'b1;
    applyStimulus(1);
    checkOutput("retgt_done_tgt_xy", 32'(target_write_xy), 0);
    checkOutput("retgt_lives", 32'(lives), 3);
    checkOutput("retgt_score", 32'(score), 0);

    // Torpedo leaves screen -> single reload, re-check held off one cycle
    torpedo_within_screen = 1'b0;
    applyStimulus(1);
    checkOutput("trp_reload", 32'(torpedo_write_xy), 1);
    applyStimulus(1);
    checkOutput("trp_holdoff", 32'(torpedo_write_xy), 0);
    torpedo_within_screen = 1'b1;
    applyStimulus(1);
    checkOutput("trp_back", 32'(torpedo_write_xy), 0);

    // Collision and wall edge together: life lost, score unchanged
    target_hit_wall = 1'b1;
    applyStimulus(1);
    collision       = 1'b1;
    target_hit_wall = 1'b0;
    applyStimulus(1);
    checkOutput("colwall_lives", 32'(lives), 2);
    checkOutput("colwall_score", 32'(score), 0);
    collision = 1'b0;
    applyStimulus(3);
    checkOutput("colwall_play_en", 32'(target_enable_update), 1);
    wallPulse();
    checkOutput("post_colwall_score", 32'(score), 1);

    // Reset during RETARGET
    target_within_screen = 1'b0;
    applyStimulus(1);
    checkOutput("pre_rst_retgt", 32'(target_write_xy), 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_tgt_xy", 32'(target_write_xy), 0);
    checkOutput("midrst_tgt_dxy", 32'(target_write_dxy), 0);
    checkOutput("midrst_tgt_en", 32'(target_enable_update), 0);
    checkOutput("midrst_lives", 32'(lives), 3);
    checkOutput("midrst_score", 32'(score), 0);
    checkOutput("midrst_speed", 32'(speed), 1);
    target_within_screen = 1'b1;
    applyStimulus(2);
    checkOutput("inrst_trp_dxy", 32'(torpedo_write_dxy), 0);
    rst = 1'b0;
    applyStimulus(3);
    checkOutput("postrst_tgt_xy", 32'(target_write_xy), 0);
    checkOutput("postrst_trp_xy", 32'(torpedo_write_xy), 0);
    checkOutput("postrst_en", 32'(torpedo_enable_update), 0);
    launch_key = 1'b1;
    applyStimulus(2);
    checkOutput("postrst_spawn", 32'(torpedo_write_xy), 1);
    launch_key = 1'b0;
    applyStimulus(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
